// File: rtl/sad_min_tracker_if.sv
// Handshake and result bus between the SAD stream source and the minimum tracker.
interface sad_min_tracker_if #(
    parameter int unsigned SAD_W = 32
);
    logic             Start;
    logic [SAD_W-1:0] SadIn;
    logic             SadValid;
    logic             SadReady;
    logic             Busy;
    logic             Done;
    logic [31:0]      xCoord;
    logic [31:0]      yCoord;
    logic [31:0]      sad;

    modport master (
        output Start, SadIn, SadValid,
        input  SadReady, Busy, Done, xCoord, yCoord, sad
    );

    modport slave (
        input  Start, SadIn, SadValid,
        output SadReady, Busy, Done, xCoord, yCoord, sad
    );
endinterface

// File: rtl/sad_min_tracker.sv
// Tracks the minimum SAD over a raster scan of candidate positions and
// publishes the best-match coordinates when the scan completes.
module sad_min_tracker #(
    parameter int unsigned FRAME_W    = 64,
    parameter int unsigned FRAME_H    = 64,
    parameter int unsigned WIN_W      = 4,
    parameter int unsigned WIN_H      = 4,
    parameter int unsigned SAD_W      = 32,
    parameter bit          EARLY_EXIT = 1'b0
) (
    input  logic                 Clk,
    input  logic                 Rst,
    sad_min_tracker_if.slave     bus
);

    localparam int unsigned XMAX = FRAME_W - WIN_W;
    localparam int unsigned YMAX = FRAME_H - WIN_H;
    localparam int unsigned XW   = (XMAX > 0) ? $clog2(XMAX + 1) : 1;
    localparam int unsigned YW   = (YMAX > 0) ? $clog2(YMAX + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [XW-1:0]    r_x;
    logic [YW-1:0]    r_y;
    logic [XW-1:0]    r_best_x;
    logic [YW-1:0]    r_best_y;
    logic [SAD_W-1:0] r_best_sad;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic [31:0]      r_x_out;
    logic [31:0]      r_y_out;
    logic [31:0]      r_sad_out;

    logic             w_accept;
    logic             w_take;
    logic             w_exit;
    logic             w_last;
    logic [XW-1:0]    w_nb_x;
    logic [YW-1:0]    w_nb_y;
    logic [SAD_W-1:0] w_nb_sad;

    // Candidate best after folding in the current sample; ties keep the earlier position.
    always_comb begin
        w_accept = bus.SadValid && r_ready;
        w_exit   = EARLY_EXIT && (bus.SadIn == '0);
        w_take   = (bus.SadIn < r_best_sad) || w_exit;
        w_last   = (r_x == XW'(XMAX)) && (r_y == YW'(YMAX));
        w_nb_x   = w_take ? r_x        : r_best_x;
        w_nb_y   = w_take ? r_y        : r_best_y;
        w_nb_sad = w_take ? bus.SadIn  : r_best_sad;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state    <= S_IDLE;
            r_x        <= '0;
            r_y        <= '0;
            r_best_x   <= '0;
            r_best_y   <= '0;
            r_best_sad <= '0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_x_out    <= '0;
            r_y_out    <= '0;
            r_sad_out  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.Start) begin
                        r_state    <= S_SCAN;
                        r_x        <= '0;
                        r_y        <= '0;
                        r_best_x   <= '0;
                        r_best_y   <= '0;
                        r_best_sad <= '1;
                        r_ready    <= 1'b1;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                    end
                end
                S_SCAN: begin
                    if (w_accept) begin
                        r_best_x   <= w_nb_x;
                        r_best_y   <= w_nb_y;
                        r_best_sad <= w_nb_sad;
                        if (w_last || w_exit) begin
                            r_state   <= S_DONE;
                            r_ready   <= 1'b0;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_x_out   <= 32'(w_nb_x);
                            r_y_out   <= 32'(w_nb_y);
                            r_sad_out <= 32'(w_nb_sad);
                        end else if (r_x == XW'(XMAX)) begin
                            r_x <= '0;
                            r_y <= r_y + YW'(1);
                        end else begin
                            r_x <= r_x + XW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.SadReady = r_ready;
    assign bus.Busy     = r_busy;
    assign bus.Done     = r_done;
    assign bus.xCoord   = r_x_out;
    assign bus.yCoord   = r_y_out;
    assign bus.sad      = r_sad_out;

endmodule

// File: tb/tb_sad_min_tracker.sv
// Directed bench for sad_min_tracker on an 8x6 frame with a 4x4 window (15 positions);
// a second instance with early exit enabled receives the same stimulus.
module tb_sad_min_tracker;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cycles;
    logic [31:0] vec [15];

    always #5 Clk = ~Clk;

    sad_min_tracker_if #(.SAD_W(32)) if0 ();
    sad_min_tracker_if #(.SAD_W(32)) if1 ();

    sad_min_tracker #(
        .FRAME_W(8), .FRAME_H(6), .WIN_W(4), .WIN_H(4), .SAD_W(32), .EARLY_EXIT(1'b0)
    ) u_dut0 (
        .Clk(Clk), .Rst(Rst), .bus(if0.slave)
    );

    sad_min_tracker #(
        .FRAME_W(8), .FRAME_H(6), .WIN_W(4), .WIN_H(4), .SAD_W(32), .EARLY_EXIT(1'b1)
    ) u_dut1 (
        .Clk(Clk), .Rst(Rst), .bus(if1.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic st, input logic v, input logic [31:0] d);
        if0.Start = st; if0.SadValid = v; if0.SadIn = d;
        if1.Start = st; if1.SadValid = v; if1.SadIn = d;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_res(input string tag, input logic [31:0] x, input logic [31:0] y,
                             input logic [31:0] s);
        check({tag, "_done"},  32'(if0.Done), 32'd1);
        check({tag, "_busy"},  32'(if0.Busy), 32'd0);
        check({tag, "_ready"}, 32'(if0.SadReady), 32'd0);
        check({tag, "_x"},     if0.xCoord, x);
        check({tag, "_y"},     if0.yCoord, y);
        check({tag, "_sad"},   if0.sad, s);
    endtask

    // Start pulse, then feed vec[0..14] with optional 1-of-3 valid pattern.
    task automatic run_scan(input string tag, input bit gap, input bit start_mid,
                            input bit hold_chk, input logic [31:0] hx, input logic [31:0] hy,
                            input logic [31:0] hs, input bit ee_chk, output int cyc_out);
        int   idx;
        int   cyc;
        logic v;
        logic acc;
        drive(1'b1, 1'b0, 32'd0);
        tick();
        drive(1'b0, 1'b0, 32'd0);
        check({tag, "_start_busy"}, 32'(if0.Busy), 32'd1);
        check({tag, "_start_done"}, 32'(if0.Done), 32'd0);
        idx = 0;
        cyc = 0;
        while (idx < 15 && cyc < 100) begin
            v   = !gap || (cyc % 3 == 0);
            acc = v && if0.SadReady;
            drive(start_mid && (idx == 5) && v, v, vec[idx]);
            if (hold_chk) begin
                check({tag, "_hold_x"},   if0.xCoord, hx);
                check({tag, "_hold_y"},   if0.yCoord, hy);
                check({tag, "_hold_sad"}, if0.sad, hs);
            end
            if (acc && idx == 14) check({tag, "_pre_done"}, 32'(if0.Done), 32'd0);
            tick();
            cyc++;
            if (acc) idx++;
            if (ee_chk && acc && idx == 7) begin
                check({tag, "_ee_done"},  32'(if1.Done), 32'd1);
                check({tag, "_ee_ready"}, 32'(if1.SadReady), 32'd0);
                check({tag, "_ee_x"},     if1.xCoord, 32'd1);
                check({tag, "_ee_y"},     if1.yCoord, 32'd1);
                check({tag, "_ee_sad"},   if1.sad, 32'd0);
            end
        end
        drive(1'b0, 1'b0, 32'd0);
        check({tag, "_accepts"}, 32'(idx), 32'd15);
        cyc_out = cyc;
    endtask

    initial begin
        drive(1'b0, 1'b0, 32'd0);
        Rst = 1'b0;
        repeat (3) @(posedge Clk);
        #1 Rst = 1'b1;
        tick();
        check("rst_ready", 32'(if0.SadReady), 32'd0);
        check("rst_busy",  32'(if0.Busy), 32'd0);
        check("rst_done",  32'(if0.Done), 32'd0);
        check("rst_x",     if0.xCoord, 32'd0);
        check("rst_y",     if0.yCoord, 32'd0);
        check("rst_sad",   if0.sad, 32'd0);

        // Reset mid-scan after 7 samples
        drive(1'b1, 1'b0, 32'd0);
        tick();
        drive(1'b0, 1'b1, 32'd5);
        repeat (7) tick();
        check("mid_busy_pre", 32'(if0.Busy), 32'd1);
        Rst = 1'b0;
        #1;
        check("mid_busy",  32'(if0.Busy), 32'd0);
        check("mid_done",  32'(if0.Done), 32'd0);
        check("mid_ready", 32'(if0.SadReady), 32'd0);
        check("mid_x",     if0.xCoord, 32'd0);
        check("mid_y",     if0.yCoord, 32'd0);
        check("mid_sad",   if0.sad, 32'd0);
        check("mid_busy1", 32'(if1.Busy), 32'd0);
        drive(1'b0, 1'b0, 32'd0);
        #2 Rst = 1'b1;
        tick();
        check("mid_idle_done", 32'(if0.Done), 32'd0);

        // Basic: min 37 at index 8 -> (3,1)
        for (int i = 0; i < 15; i++) vec[i] = 32'd100;
        vec[8] = 32'd37;
        run_scan("basic", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, cycles);
        check("basic_cycles", 32'(cycles), 32'd15);
        check_res("basic", 32'd3, 32'd1, 32'd37);
        check("basic_ee_sad", if1.sad, 32'd37);

        // Ties keep first position
        for (int i = 0; i < 15; i++) vec[i] = 32'd50;
        run_scan("tie", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, cycles);
        check_res("tie", 32'd0, 32'd0, 32'd50);

        // Last position wins; outputs hold previous result during scan
        for (int i = 0; i < 15; i++) vec[i] = 32'd60;
        vec[14] = 32'd10;
        run_scan("last", 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd50, 1'b0, cycles);
        check_res("last", 32'd4, 32'd2, 32'd10);

        // Stalls: valid on every third cycle
        for (int i = 0; i < 15; i++) vec[i] = 32'd100;
        vec[8] = 32'd37;
        run_scan("stall", 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, cycles);
        check("stall_cycles", 32'(cycles), 32'd43);
        check_res("stall", 32'd3, 32'd1, 32'd37);

        // Start during scan is ignored
        vec[8] = 32'd100;
        vec[2] = 32'd20;
        vec[9] = 32'd21;
        run_scan("smid", 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, cycles);
        check("smid_cycles", 32'(cycles), 32'd15);
        check_res("smid", 32'd2, 32'd0, 32'd20);

        // Zero at index 6: early-exit instance stops, the other runs all 15
        for (int i = 0; i < 15; i++) vec[i] = 32'd100;
        vec[6] = 32'd0;
        run_scan("zero", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, cycles);
        check("zero_cycles", 32'(cycles), 32'd15);
        check_res("zero", 32'd1, 32'd1, 32'd0);
        check("zero_ee_ready", 32'(if1.SadReady), 32'd0);
        check("zero_ee_done",  32'(if1.Done), 32'd1);
        check("zero_ee_x",     if1.xCoord, 32'd1);
        check("zero_ee_y",     if1.yCoord, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sad_min_tracker.md
Name: sad_min_tracker

Overview:
- Downstream of the SAD computation stage in the motion-estimation datapath.
- Consumes one SAD value per candidate window position, in raster order over the search frame.
- Tracks the minimum SAD and publishes the best-match coordinates on xCoord/yCoord/sad with a Done flag.
- Sits between the SAD engine and top-level outputs; owns position counting so the SAD engine only streams values.

Parameters:
- FRAME_W, 64, frame width in pixels
- FRAME_H, 64, frame height in pixels
- WIN_W, 4, template window width
- WIN_H, 4, template window height
- SAD_W, 32, SAD input width
- EARLY_EXIT, 0, when 1 a SAD of zero ends the scan immediately

Ports:
- Clk  input  1  system clock, rising edge
- Rst  input  1  asynchronous, active-low reset
- Start  input  1  single-cycle pulse; begins a scan
- SadIn  input  SAD_W  SAD for the current candidate position
- SadValid  input  1  SadIn is valid this cycle
- SadReady  output  1  tracker accepts SadIn this cycle
- Busy  output  1  scan in progress
- Done  output  1  result valid; held until next Start
- xCoord  output  32  column of best match, zero-extended
- yCoord  output  32  row of best match, zero-extended
- sad  output  32  best SAD, zero-extended or truncated to 32

Behaviour:
- Reset (Rst=0, async):
  - State to IDLE.
  - SadReady, Busy, Done, xCoord, yCoord and sad all 0.
  - Internal counters and best registers cleared.
  - Reset mid-scan aborts the scan. No partial result is published.
- Positions: x = 0..FRAME_W-WIN_W, y = 0..FRAME_H-WIN_H.
  - Raster order, x fastest.
  - N = (FRAME_W-WIN_W+1)*(FRAME_H-WIN_H+1).
- States:
  - IDLE: SadReady=0, Busy=0. Start goes to SCAN.
  - SCAN: SadReady=1, Busy=1.
  - DONE: Done=1, SadReady=0, Busy=0. Start goes to SCAN and clears Done on the same edge.
- On entering SCAN:
  - Counters set to (0,0).
  - Internal bestSad set to all ones (2^SAD_W-1). Internal best coordinates set to 0.
- Accept rule: a sample is accepted on a rising edge with SadValid=1 and SadReady=1.
  - The sample belongs to the current counter position.
  - SadValid=0 stalls the counters; gaps are unlimited.
- Compare rule:
  - If SadIn < bestSad (strict, unsigned), update bestSad and the best coordinates to the current position.
  - Ties keep the earlier position.
- Counter advance:
  - x increments. At x = FRAME_W-WIN_W, x wraps to 0 and y increments.
- Completion: accepting position (FRAME_W-WIN_W, FRAME_H-WIN_H) moves the block to DONE on the same edge.
  - Include that final sample in the compare.
  - Published outputs load on that edge.
  - Latency: Done=1 and new outputs appear in the cycle immediately after the last accept.
- Early exit: if EARLY_EXIT=1 and an accepted SadIn is 0, that position is recorded and the block goes to DONE on the same edge.
  - Remaining positions are not consumed.
  - With EARLY_EXIT=0, a SAD of 0 is an ordinary minimum and the scan continues.
- Output holding: xCoord, yCoord and sad change only on the DONE-entry edge.
  - They hold the previous result throughout a subsequent scan and in IDLE.
- Start handling: Start during SCAN is ignored. Start in IDLE or DONE begins a new scan.
- Widths: coordinates are zero-extended to 32 bits. If SAD_W > 32, sad carries the low 32 bits.

Test Plan:
- Bench parameters: FRAME_W=8, FRAME_H=6, WIN 4x4, so 5x3 = 15 positions.
1. Reset: hold Rst=0 for 3 cycles, then release -> all outputs 0, SadReady=0. Asserting Rst=0 mid-scan, after 7 samples -> Busy=0 and Done=0 immediately, outputs keep their prior values (0).
2. Basic: Start, then 15 back-to-back samples with SadIn=100, except 37 at index 8 -> Done=1 one cycle after the 15th accept; xCoord=3, yCoord=1, sad=37.
3. Tie and first/last position:
   - All samples 50 -> (0,0), sad=50.
   - Then a new Start with 60s everywhere except 10 at index 14 -> (4,2), sad=10.
   - During the second scan, outputs must hold (0,0,50) until its Done.
4. Stalls: same data as scenario 2, with SadValid toggled 1,0,0,1,... -> identical result (3,1,37). No samples are lost or double-counted; the Done cycle is shifted by the gap cycles.
5. Start ignored: a Start pulse at sample 5 of a scan -> scan continues; Done comes after the 15th accept.
6. Early exit: EARLY_EXIT=1, SadIn=0 at index 6 -> Done on the next cycle; xCoord=1, yCoord=1, sad=0; SadReady=0 from then on. The same stimulus with EARLY_EXIT=0 -> scan runs all 15 samples with the same result.
